// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - PS/2 set-2 scancode parser with typematic filter and event FIFO.
// Optional PS2_KEY_ASCII_EN adds a set-2 to ASCII lookup on the head event.
module ps2_key_event #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_ascii,
    output logic       held,
    output logic [7:0] key_count,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t     state, state_next;
    logic       fire, fire_ext, fire_brk;
    logic [8:0] held_key;
    logic       suppress, push, pop, wr_en, full;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        fire_ext   = 1'b0;
        fire_brk   = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (byte_in == 8'hE0)      state_next = GOT_E0;
                    else if (byte_in == 8'hF0) state_next = GOT_F0;
                    else                       fire = 1'b1;
                end
                GOT_E0: begin
                    if (byte_in == 8'hF0)      state_next = GOT_E0F0;
                    else if (byte_in != 8'hE0) begin
                        fire     = 1'b1;
                        fire_ext = 1'b1;
                    end
                end
                GOT_F0: begin
                    if (byte_in != 8'hF0) begin
                        fire     = 1'b1;
                        fire_brk = 1'b1;
                    end
                end
                GOT_E0F0: begin
                    if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                        fire     = 1'b1;
                        fire_ext = 1'b1;
                        fire_brk = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (fire) state_next = IDLE;
        end
    end

    // A press of the key already held is keyboard auto-repeat and is swallowed.
    assign suppress = fire && !fire_brk && held && (held_key == {fire_ext, byte_in});
    assign push     = fire && !suppress;
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = (count != '0) && evt_ready;
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held      <= 1'b0;
            held_key  <= '0;
            key_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push && !fire_brk) begin
                held      <= 1'b1;
                held_key  <= {fire_ext, byte_in};
                key_count <= key_count + 8'd1;
            end else if (push && fire_brk && held_key == {fire_ext, byte_in}) begin
                held <= 1'b0;
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {fire_ext, fire_brk, byte_in};
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_break = evt_valid & head[8];
    assign evt_ext   = evt_valid & head[9];

`ifdef PS2_KEY_ASCII_EN
    function automatic logic [7:0] set2_ascii(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
            8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
            8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
            8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
            8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
            8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
            8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
            8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
            8'h35: return 8'h59;  8'h1A: return 8'h5A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    assign evt_ascii = (evt_valid && !evt_ext) ? set2_ascii(evt_code) : 8'h00;
`else
    assign evt_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_event.sv
// tb/tb_ps2_key_event.sv - randomized and directed bench for ps2_key_event against a prefix-flag event model.
module tb_ps2_key_event;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, byte_valid, evt_ready;
    logic [7:0] byte_in;
    logic       evt_valid, evt_ext, evt_break, held, overflow;
    logic [7:0] evt_code, evt_ascii, key_count;

    ps2_key_event #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .evt_ascii(evt_ascii),
        .held(held), .key_count(key_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: pending prefix flags, a queue of {ext,brk,code}, and key bookkeeping.
    logic [9:0] q[$];
    bit         m_ext, m_brk, m_held, m_ovf;
    logic [8:0] m_hk;
    logic [7:0] m_kc;
    int         n_pop;

`ifdef PS2_KEY_ASCII_EN
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
`endif

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit e);
`ifdef PS2_KEY_ASCII_EN
        if (e) return 8'h00;
        for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h41 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
`else
        return 8'h00 & {c[7:1], e};
`endif
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_held = 0; m_ovf = 0;
        m_hk = '0; m_kc = '0;
    endfunction

    function automatic void model_step(input bit bv, input logic [7:0] b, input bit rdy);
        bit fire = 0, e = 0, k = 0, pop;
        pop = (q.size() != 0) && rdy;
        if (bv) begin
            if (b == 8'hE0) begin
                if (!m_brk) m_ext = 1;
                else if (!m_ext) begin fire = 1; k = 1; end
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                fire = 1; e = m_ext; k = m_brk;
            end
            if (fire) begin m_ext = 0; m_brk = 0; end
        end
        if (pop) void'(q.pop_front());
        if (fire && !(!k && m_held && m_hk == {e, b})) begin
            if (!k) begin
                m_held = 1; m_hk = {e, b}; m_kc = m_kc + 8'd1;
            end else if (m_hk == {e, b}) begin
                m_held = 0;
            end
            if (q.size() == DEPTH) m_ovf = 1;
            else q.push_back({e, k, b});
        end
    endfunction

    task automatic check_outputs();
        check("evt_valid", evt_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("evt_code", evt_code, q[0][7:0]);
            check("evt_ext", evt_ext, q[0][9]);
            check("evt_break", evt_break, q[0][8]);
            check("evt_ascii", evt_ascii, ref_ascii(q[0][7:0], q[0][9]));
        end else begin
            check("evt_code_empty", evt_code, 8'h00);
        end
        check("held", held, m_held);
        check("key_count", key_count, m_kc);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit bv, input logic [7:0] b, input bit rdy);
        byte_valid = bv; byte_in = b; evt_ready = rdy;
        if (evt_valid && rdy) n_pop++;
        model_step(bv, b, rdy);
        @(posedge clk);
        #1;
        byte_valid = 0; evt_ready = 0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        check("rst_valid", evt_valid, 1'b0);
        check("rst_code", {evt_code, evt_ascii}, 16'h0000);
        check("rst_flags", {evt_ext, evt_break, held, overflow}, 4'b0000);
        check("rst_count", key_count, 8'h00);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic drain_expect(input logic [7:0] exp0, input logic [7:0] exp1,
                                input logic [7:0] exp2, input logic [7:0] exp3);
        logic [7:0] exp [4];
        exp = '{exp0, exp1, exp2, exp3};
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", evt_valid, 1'b1);
            check("drain_code", evt_code, exp[i]);
            step(0, 8'h00, 1);
        end
        check("drain_empty", evt_valid, 1'b0);
    endtask

    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'hE0};

    initial begin
        rst = 1; byte_valid = 0; evt_ready = 0; byte_in = 8'h00;
        model_reset();
        n_pop = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Press and release of A
        step(1, 8'h1C, 0);
        check("pr_held", held, 1'b1);
        check("pr_first", {evt_ext, evt_break, evt_code}, 10'h01C);
        step(1, 8'hF0, 1);
        step(1, 8'h1C, 0);
        check("pr_release", {evt_ext, evt_break, evt_code}, 10'h11C);
        check("pr_held_clr", held, 1'b0);
        check("pr_count", key_count, 8'd1);
        step(0, 8'h00, 1);

        // Extended cursor key
        do_reset();
        step(1, 8'hE0, 1);
        step(1, 8'h75, 0);
        check("ext_press", {evt_ext, evt_break, evt_code, evt_ascii}, 18'h20000 | 18'h07500);
        step(1, 8'hE0, 1);
        step(1, 8'hF0, 0);
        step(1, 8'h75, 0);
        check("ext_release", {evt_ext, evt_break, evt_code}, 10'h375);
        check("ext_held_clr", held, 1'b0);
        step(0, 8'h00, 1);

        // Typematic repeat
        do_reset();
        n_pop = 0;
        for (int i = 0; i < 5; i++) step(1, 8'h1C, 1);
        step(1, 8'hF0, 1);
        step(1, 8'h1C, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        check("typ_events", n_pop, 2);
        check("typ_count", key_count, 8'd1);

        // Overflow with consumer stalled
        do_reset();
        step(1, 8'h1C, 0);
        step(1, 8'h32, 0);
        step(1, 8'h21, 0);
        step(1, 8'h23, 0);
        check("ovf_before", overflow, 1'b0);
        step(1, 8'h24, 0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", key_count, 8'd5);
        drain_expect(8'h1C, 8'h32, 8'h21, 8'h23);
        check("ovf_sticky", overflow, 1'b1);

        // Push and pop together while full
        do_reset();
        step(1, 8'h1C, 0);
        step(1, 8'h32, 0);
        step(1, 8'h21, 0);
        step(1, 8'h23, 0);
        step(1, 8'h24, 1);
        check("pp_overflow", overflow, 1'b0);
        drain_expect(8'h32, 8'h21, 8'h23, 8'h24);

        // Reset in the middle of a prefix sequence
        do_reset();
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        do_reset();
        step(1, 8'h1C, 0);
        check("rm_event", {evt_valid, evt_ext, evt_break, evt_code}, 11'h41C);
        check("rm_count", key_count, 8'd1);

        // Random traffic, readiness bias changing per phase
        for (int ph = 0; ph < 5; ph++) begin
            int bias = ph % 3;
            do_reset();
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)],
                     $urandom_range(0, 3) < 3 - bias);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_event.md
PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  received PS/2 scancode byte from the keyboard receiver.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe; byte_in is valid this cycle.
REQ-006 SHALL have port evt_ready  input  1  consumer accepts the head event this cycle.
REQ-007 SHALL have port evt_valid  output  1  FIFO non-empty; head event presented.
REQ-008 SHALL have port evt_code  output  8  head event scancode, prefixes stripped.
REQ-009 SHALL have port evt_ext  output  1  head event carried the E0 prefix.
REQ-010 SHALL have port evt_break  output  1  head event is a release (F0 prefix); 0 = press.
REQ-011 SHALL have port evt_ascii  output  8  ASCII of head event (see Configuration).
REQ-012 SHALL have port held  output  1  a key is currently held.
REQ-013 SHALL have port key_count  output  8  count of accepted presses, modulo 256.
REQ-014 SHALL have port overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-015 SHALL parse bytes with FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0; state advances only on byte_valid.
REQ-016 SHALL transition: IDLE+E0->GOT_E0; IDLE+F0->GOT_F0; GOT_E0+F0->GOT_E0F0; GOT_E0+E0->GOT_E0; GOT_F0+F0->GOT_F0; GOT_E0F0+E0/F0->GOT_E0F0; any state + other byte -> event built, ->IDLE.
REQ-017 SHALL form events as: code=byte_in, ext=1 in GOT_E0/GOT_E0F0, break=1 in GOT_F0/GOT_E0F0.
REQ-018 SHALL suppress a press event whose {ext,code} equals the held key while held=1 (typematic repeat): no push, no count change.
REQ-019 SHALL, on an accepted press: push event, set held=1, record {ext,code} as held key, increment key_count (255 wraps to 0).
REQ-020 SHALL, on a release: always push event; clear held only if {ext,code} matches the held key.
REQ-021 SHALL make a pushed event visible on evt_valid the cycle after the byte_valid of its final byte (1-cycle latency, first-word-fallthrough).
REQ-022 SHALL pop the head when evt_valid && evt_ready; evt_ready while empty has no effect.
REQ-023 SHALL, on push while full with no pop that cycle, drop the new event and set overflow=1; held/key_count still update.
REQ-024 SHALL, on simultaneous push and pop while full, accept both; occupancy unchanged, no overflow.
REQ-025 SHALL wrap FIFO read/write pointers modulo DEPTH; occupancy tracked 0..DEPTH.

Reset
REQ-026 SHALL, while rst=1, force FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, evt_ascii=0, held=0, key_count=0, overflow=0.
REQ-027 SHALL discard any partially received prefix sequence on reset mid-operation; overflow clears only on reset.

Configuration
REQ-028 SHALL, with PS2_KEY_ASCII_EN defined, drive evt_ascii from a set-2 table for non-extended codes: letters -> 0x41-0x5A (e.g. 1C->41), digits 45,16,1E,26,25,2E,36,3D,3E,46 -> 0x30-0x39, 29->0x20, 5A->0x0D, 66->0x08; all others and ext=1 -> 0x00.
REQ-029 SHALL, without PS2_KEY_ASCII_EN, tie evt_ascii to 0x00 and build no table.

Verification
REQ-030 SHALL cover press/release: bytes 1C, F0, 1C, evt_ready=1 -> events {1C,ext0,brk0,ascii41},{1C,ext0,brk1}; key_count=1; held 1 then 0.
REQ-031 SHALL cover extended: E0, 75, E0, F0, 75 -> {75,ext1,brk0,ascii00},{75,ext1,brk1}; held cleared.
REQ-032 SHALL cover typematic: 1C x5, then F0, 1C -> exactly two events; key_count=1.
REQ-033 SHALL cover overflow: evt_ready=0, presses 1C,32,21,23,24 with releases omitted -> 4 events held, overflow=1, key_count=5; drain in order 1C,32,21,23.
REQ-034 SHALL cover full push+pop: FIFO full, final byte of new event in the same cycle as evt_ready=1 -> occupancy stays 4, overflow=0.
REQ-035 SHALL cover reset mid-sequence: E0, F0, assert rst, release, then 1C -> single event {1C,ext0,brk0}, key_count=1.
